// File: rtl/sm_window_avg_filter.sv
// Four-channel sign-magnitude moving-average filter over 2^LOG2_TAPS frames.
// Registered outputs with a valid/ready handshake and no skid buffer.
module sm_window_avg_filter #(
  parameter int DATA_W    = 16,
  parameter int LOG2_TAPS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic [DATA_W-1:0] data_in4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic [DATA_W-1:0] data_out3,
  output logic [DATA_W-1:0] data_out4,
  output logic              warm
);

  localparam int TAPS = 1 << LOG2_TAPS;
  localparam int SW   = DATA_W + LOG2_TAPS;
  localparam int UW   = LOG2_TAPS + 1;

  typedef logic signed [DATA_W-1:0] samp_t;
  typedef logic signed [SW-1:0]     sum_t;

  samp_t              hist   [4][TAPS];
  sum_t               sum_q  [4];
  logic [DATA_W-1:0]  dout_q [4];
  logic [LOG2_TAPS-1:0] wptr;
  logic [LOG2_TAPS:0]   fill;

  logic [DATA_W-1:0]  din    [4];
  samp_t              conv   [4];
  sum_t               sum_nx [4];
  sum_t               abs_v  [4];
  logic [DATA_W-1:0]  enc    [4];
  logic [4*UW-1:0]    unused_bits;
  logic               accept;

  assign din[0] = data_in1;
  assign din[1] = data_in2;
  assign din[2] = data_in3;
  assign din[3] = data_in4;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign warm     = (fill == UW'(TAPS));

  assign data_out1 = dout_q[0];
  assign data_out2 = dout_q[1];
  assign data_out3 = dout_q[2];
  assign data_out4 = dout_q[3];

  // Magnitude is abs(sum)/TAPS; sign is dropped when it truncates to zero.
  always_comb begin
    unused_bits = '0;
    for (int ch = 0; ch < 4; ch++) begin
      samp_t m;
      logic [DATA_W-2:0] mag;
      m = samp_t'({1'b0, din[ch][DATA_W-2:0]});
      conv[ch]   = din[ch][DATA_W-1] ? -m : m;
      sum_nx[ch] = sum_q[ch] + sum_t'(conv[ch])
                 - sum_t'(hist[ch][wptr]);
      abs_v[ch]  = sum_nx[ch][SW-1] ? -sum_nx[ch] : sum_nx[ch];
      mag        = abs_v[ch][SW-2:LOG2_TAPS];
      enc[ch]    = {sum_nx[ch][SW-1] && (mag != '0), mag};
      unused_bits[ch*UW +: UW] =
        {abs_v[ch][SW-1], abs_v[ch][LOG2_TAPS-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      wptr      <= '0;
      fill      <= '0;
      for (int ch = 0; ch < 4; ch++) begin
        sum_q[ch]  <= '0;
        dout_q[ch] <= '0;
        for (int t = 0; t < TAPS; t++) begin
          hist[ch][t] <= '0;
        end
      end
    end else if (accept) begin
      for (int ch = 0; ch < 4; ch++) begin
        hist[ch][wptr] <= conv[ch];
        sum_q[ch]      <= sum_nx[ch];
        dout_q[ch]     <= enc[ch];
      end
      wptr      <= wptr + 1'b1;
      out_valid <= 1'b1;
      if (fill != UW'(TAPS)) begin
        fill <= fill + 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sm_window_avg_filter.sv
// Bench for sm_window_avg_filter: directed plan plus random traffic
// against a window-sum reference model.
module tb_sm_window_avg_filter;

  localparam int TAPS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] data_in1 = '0;
  logic [15:0] data_in2 = '0;
  logic [15:0] data_in3 = '0;
  logic [15:0] data_in4 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] data_out1;
  logic [15:0] data_out2;
  logic [15:0] data_out3;
  logic [15:0] data_out4;
  logic        warm;

  int n_chk = 0;
  int n_err = 0;

  int          win [4][$];
  int          m_cnt;
  bit          m_valid;
  logic [15:0] m_data [4];

  always #5 clk = ~clk;

  sm_window_avg_filter #(.DATA_W(16), .LOG2_TAPS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in1  (data_in1),
    .data_in2  (data_in2),
    .data_in3  (data_in3),
    .data_in4  (data_in4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out1 (data_out1),
    .data_out2 (data_out2),
    .data_out3 (data_out3),
    .data_out4 (data_out4),
    .warm      (warm)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int sm2int(input logic [15:0] x);
    return x[15] ? -int'(x[14:0]) : int'(x[14:0]);
  endfunction

  function automatic logic [15:0] int2sm(input int s);
    int a;
    a = s / TAPS;
    if (a < 0) return {1'b1, 15'(-a)};
    return {1'b0, 15'(a)};
  endfunction

  function automatic void model_reset();
    for (int ch = 0; ch < 4; ch++) begin
      win[ch].delete();
      for (int t = 0; t < TAPS; t++) win[ch].push_back(0);
      m_data[ch] = '0;
    end
    m_cnt   = 0;
    m_valid = 0;
  endfunction

  function automatic void model_accept(input logic [15:0] d [4]);
    for (int ch = 0; ch < 4; ch++) begin
      int s;
      win[ch].push_back(sm2int(d[ch]));
      void'(win[ch].pop_front());
      s = 0;
      foreach (win[ch][k]) s += win[ch][k];
      m_data[ch] = int2sm(s);
    end
    if (m_cnt < TAPS) m_cnt++;
    m_valid = 1;
  endfunction

  task automatic cycle(input bit v, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] c,
                       input logic [15:0] e, input bit ordy,
                       input bit r);
    logic [15:0] d [4];
    bit          exp_rdy;
    d = '{a, b, c, e};
    in_valid = v;
    data_in1 = a;
    data_in2 = b;
    data_in3 = c;
    data_in4 = e;
    out_ready = ordy;
    rst = r;
    exp_rdy = !m_valid || ordy;
    #1;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    if (r) model_reset();
    else if (v && exp_rdy) model_accept(d);
    else if (ordy) m_valid = 0;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("warm", 32'(warm), 32'(m_cnt >= TAPS));
    chk("data_out1", 32'(data_out1), 32'(m_data[0]));
    chk("data_out2", 32'(data_out2), 32'(m_data[1]));
    chk("data_out3", 32'(data_out3), 32'(m_data[2]));
    chk("data_out4", 32'(data_out4), 32'(m_data[3]));
  endtask

  task automatic frame(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] e);
    cycle(1'b1, a, b, c, e, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b1);
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out", 32'(data_out1), 32'h0);

    // ramp-up then eviction back to zero
    for (int i = 0; i < 4; i++)
      frame(16'h0010, 16'h0010, 16'h0010, 16'h0010);
    chk("ramp_4th", 32'(data_out1), 32'h0010);
    chk("ramp_warm", 32'(warm), 32'd1);
    for (int i = 0; i < 4; i++)
      frame(16'h0000, 16'h0010, 16'h0000, 16'h0000);
    chk("evict_end", 32'(data_out1), 32'h0000);

    // negatives, negative-zero suppression, 0x8000 input
    do_reset();
    frame(16'h8010, 16'h8001, 16'h8000, 16'hFFFF);
    chk("negzero", 32'(data_out2), 32'h0000);
    chk("neg_1st", 32'(data_out1), 32'h8004);
    for (int i = 0; i < 3; i++)
      frame(16'h8010, 16'h0000, 16'h8000, 16'hFFFF);
    chk("neg_4th", 32'(data_out1), 32'h8010);
    chk("fs_neg", 32'(data_out4), 32'hFFFF);
    chk("in_8000", 32'(data_out3), 32'h0000);

    // full scale positive and alternating signs
    do_reset();
    for (int i = 0; i < 4; i++) begin
      frame(16'h7FFF, (i % 2 == 0) ? 16'h0064 : 16'h8064,
            16'h1234, 16'h8ABC);
      chk("alt", 32'(data_out2), (i % 2 == 0) ? 32'h19 : 32'h0);
    end
    chk("fs_pos", 32'(data_out1), 32'h7FFF);

    // backpressure with continuous in_valid
    do_reset();
    cycle(1'b1, 16'h0010, 16'h0020, 16'h8030, 16'h0040, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 16'(16'h0100 + i), 16'h0020, 16'h0030, 16'h8040,
            1'b0, 1'b0);
      chk("stall_rdy", 32'(in_ready), 32'd0);
    end
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 16'h0200, 16'h0020, 16'h0030, 16'h0040, 1'b1, 1'b0);

    // reset mid-stream
    do_reset();
    frame(16'h0010, 16'h0010, 16'h0010, 16'h0010);
    frame(16'h0010, 16'h0010, 16'h0010, 16'h0010);
    cycle(1'b1, 16'h0010, 16'h0010, 16'h0010, 16'h0010, 1'b0, 1'b1);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_warm", 32'(warm), 32'd0);
    frame(16'h0010, 16'h0010, 16'h0010, 16'h0010);
    chk("mid_rst_restart", 32'(data_out1), 32'h0004);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 16'($urandom),
            16'($urandom), 16'($urandom),
            ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 63) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sm_window_avg_filter.md
Name: sm_window_avg_filter

Overview:
- Noise-reduction stage directly downstream of the four-channel Receiver.
- Consumes the Receiver's four 16-bit sign-magnitude words (data_out1..4) as one frame per valid/ready handshake.
- Per channel, computes a moving average over the last 2^LOG2_TAPS frames.
- Emits four sign-magnitude averages per accepted frame.

Parameters:
- DATA_W, 16, sample width; bit DATA_W-1 is sign, bits DATA_W-2:0 are magnitude.
- LOG2_TAPS, 2, log2 of window length; TAPS = 2^LOG2_TAPS. Legal range 1..4.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input frame valid.
- in_ready  out  1  block can accept a frame this cycle.
- data_in1..data_in4  in  DATA_W each  channel samples, sign-magnitude.
- out_valid  out  1  output frame valid.
- out_ready  in  1  downstream accepts the output frame.
- data_out1..data_out4  out  DATA_W each  channel averages, sign-magnitude.
- warm  out  1  window full (TAPS frames accepted since reset).

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: out_valid=0, data_out1..4=0, warm=0, write pointer=0, fill counter=0, all history entries=0, all running sums=0.
- in_ready = !out_valid || out_ready. This is combinational and has no skid buffer.
- Input accept: in_valid && in_ready on a rising edge. in_valid with in_ready low is held by upstream with data stable.
- Conversion:
  - Each input is mapped to signed two's complement: value = sign ? -mag : +mag.
  - 0x8000 (negative zero) converts to 0.
  - Range is ±(2^(DATA_W-1)-1).
- State per channel:
  - Circular history of TAPS converted samples.
  - Running sum, signed, width DATA_W+LOG2_TAPS; it never overflows.
- On accept, per channel:
  - sum_next = sum + new - hist[wptr].
  - hist[wptr] <= new.
  - sum <= sum_next.
  - wptr increments and wraps from TAPS-1 to 0.
- Output encoding:
  - mag = |sum_next| >> LOG2_TAPS, i.e. truncation toward zero.
  - sign = (sum_next < 0) && (mag != 0). Negative zero is never emitted.
  - mag fits in DATA_W-1 bits.
- Latency: outputs are registered. data_outN and out_valid update on the accept edge and are visible the cycle after the input handshake. Sustained throughput is 1 frame/cycle while out_ready=1.
- Output handshake:
  - out_valid falls when out_valid && out_ready and no new accept occurs on the same edge.
  - An accept and a drain on the same edge keep out_valid=1 and load the new data.
  - data_outN is stable while out_valid && !out_ready.
- Warm-up:
  - The fill counter saturates at TAPS; warm=1 once it reaches TAPS.
  - Before warm, outputs are still divided by TAPS, because history is preloaded with zeros.
  - warm does not gate out_valid.
- Reset mid-operation: rst overrides everything on that edge. A pending output is dropped, in_ready is 1 the next cycle, and the window restarts from zeros.
- rst with in_valid=1 on the same edge: the frame is not accepted.

Test Plan:
- Ramp-up, LOG2_TAPS=2, out_ready=1:
  - Stimulus: four frames, all channels 0x0010.
  - Required: data_out = 0x0004, 0x0008, 0x000C, 0x0010 on consecutive cycles; warm rises with the 4th output.
- Negatives and rounding:
  - Stimulus: ch1 = 0x8010 ×4 → required 0x8004, 0x8008, 0x800C, 0x8010.
  - Stimulus: ch2 = 0x8001 once → required 0x0000 (not 0x8000).
  - Stimulus: ch3 = 0x8000 → treated as 0.
- Wrap and eviction:
  - Stimulus: ch1 frames 0x0010 ×4, then 0x0000 ×4.
  - Required: post-window outputs 0x000C, 0x0008, 0x0004, 0x0000; the pointer wraps correctly.
- Full scale and mixed channels:
  - Stimulus: ch1 = 0x7FFF ×4 → required 4th output 0x7FFF.
  - Stimulus: ch4 = 0xFFFF ×4 → required 4th output 0xFFFF.
  - Stimulus: ch2 alternating 0x0064 / 0x8064 → required 0x0019, 0x0000, 0x0019, 0x0000.
  - All channels are independent; no overflow.
- Backpressure:
  - Stimulus: in_valid=1 continuously; out_ready=0 for 3 cycles after the first output.
  - Required: in_ready=0 during the stall, data_out held constant, no frame lost or duplicated; sequence matches the unstalled reference once out_ready=1.
- Reset mid-stream:
  - Stimulus: assert rst for 1 cycle after 2 frames of 0x0010.
  - Required: next cycle out_valid=0, warm=0, in_ready=1; the following frame of 0x0010 yields 0x0004.
